err_rcvr: RTL

Receiving end of the error-reporting four-phase handshake (`err_req`/`err_ack`/32-bit data). It acknowledges each error word, buffers it in a small show-ahead FIFO, and exposes the FIFO plus a saturating error counter to the host register interface. It sits between the error manager's `err_out`/`err_req`/`err_ack` port and the slow-control register map.

---
 rtl/err_rcvr_pkg.sv | 11 +
 rtl/err_rcvr_if.sv | 9 +
 rtl/err_rcvr_fifo.sv | 51 +++++
 rtl/err_rcvr.sv | 79 +++++++
 4 files changed

// File: rtl/err_rcvr_pkg.sv
// Shared definitions for the error-report receiver: handshake FSM encodings and word width.
package err_rcvr_pkg;
  localparam int          ERR_DW  = 32;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_ACK          = 2'd1,
    S_WAIT_REQ_LOW = 2'd2
  } state_e;
endpackage

// File: rtl/err_rcvr_if.sv
// Four-phase error-report link: sender drives req/data, receiver returns ack.
interface err_rcvr_if #(parameter int DW = 32);
  logic          err_req;
  logic [DW-1:0] err_data;
  logic          err_ack;

  modport master (output err_req, err_data, input  err_ack);
  modport slave  (input  err_req, err_data, output err_ack);
endinterface

// File: rtl/err_rcvr_fifo.sv
// Single-clock show-ahead FIFO with a registered head word and a registered empty flag.
module err_fifo #(
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign full    = (count == DEPTH);
  // Pop needs real data and a head the host could actually have seen.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty && (count != '0);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Head lags pointer/count by one edge so a new word shows one cycle after its write.
      dout  <= (count != '0) ? mem[rd_ptr] : '0;
      empty <= (count == '0);
    end
  end
endmodule

// File: rtl/err_rcvr.sv
// Error-report receiver: acks each request, queues the word, keeps a saturating accept count.
module err_rcvr
  import err_rcvr_pkg::*;
#(
  parameter int DW = ERR_DW,
  parameter int AW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  err_rcvr_if.slave      eif,
  input  logic           rd_en,
  output logic [DW-1:0]  rd_data,
  output logic           rd_empty,
  output logic [AW:0]    rd_count,
  output logic [31:0]    err_cnt,
  input  logic           cnt_clr
);
  state_e state;
  logic   fifo_full;
  logic   accept;

  // Full comes from the registered count, so a same-cycle pop cannot unblock a push.
  assign accept = (state == S_IDLE) && eif.err_req && !fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      eif.err_ack <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          eif.err_ack <= 1'b0;
          if (accept) begin
            eif.err_ack <= 1'b1;
            state       <= S_ACK;
          end
        end
        S_ACK: begin
          eif.err_ack <= 1'b1;
          if (!eif.err_req) begin
            eif.err_ack <= 1'b0;
            state       <= S_IDLE;
          end
        end
        S_WAIT_REQ_LOW: begin
          eif.err_ack <= 1'b0;
          if (!eif.err_req) state <= S_IDLE;
        end
        default: begin
          eif.err_ack <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            err_cnt <= '0;
    else if (cnt_clr)                      err_cnt <= '0;
    else if (accept && err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
  end

  err_fifo #(.DW(DW), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (rd_en),
    .din   (eif.err_data),
    .dout  (rd_data),
    .count (rd_count),
    .full  (fifo_full),
    .empty (rd_empty)
  );

`ifdef MODEL_TECH
  string state_name;
  always_comb state_name = state.name();
`endif
endmodule
